// File: rtl/temp_fan_ctrl.sv
// -----------------------------------------------------------------------------
// temp_fan_ctrl
//
// Purpose:
//   Takes the 12-bit temperature word written by software to the Temperature
//   PIO and turns it into a fan state (OFF/LOW/HIGH/ALARM). Thresholds have a
//   hysteresis band on the way down and a minimum dwell time between
//   non-alarm state changes. The block drives a glitch-free PWM fan output and
//   a registered over-temperature alarm.
//
// Ports:
//   clk        in   1         system clock, rising edge
//   reset_n    in   1         asynchronous active-low reset
//   temp_in    in   12        unsigned temperature code (clk domain)
//   fan_state  out  2         0=OFF 1=LOW 2=HIGH 3=ALARM (registered)
//   duty       out  PWM_BITS  duty currently applied to the PWM (registered)
//   fan_pwm    out  1         PWM fan drive (registered)
//   alarm      out  1         high while in ALARM (registered)
//
// Build option:
//   TEMP_FAN_SOFTSTART_EN  when defined, duty increases ramp by at most 16 per
//                          PWM period; decreases still load directly.
// -----------------------------------------------------------------------------
module temp_fan_ctrl #(
   parameter int unsigned PWM_BITS    = 8,
   parameter int unsigned PRESCALE    = 4,
   parameter logic [11:0] T_LOW       = 12'd400,
   parameter logic [11:0] T_HIGH      = 12'd600,
   parameter logic [11:0] T_ALARM     = 12'd800,
   parameter logic [11:0] HYST        = 12'd20,
   parameter int unsigned HOLD_CYCLES = 1000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [11:0]         temp_in,
   output logic [1:0]          fan_state,
   output logic [PWM_BITS-1:0] duty,
   output logic                fan_pwm,
   output logic                alarm
);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_LOW   = 2'd1,
      ST_HIGH  = 2'd2,
      ST_ALARM = 2'd3
   } state_t;

   localparam int unsigned DW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [DW-1:0] DWELL_MAX = DW'(HOLD_CYCLES - 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

   // Downward thresholds: the hysteresis band sits below each entry threshold.
   localparam logic [11:0] T_LOW_DN   = T_LOW - HYST;
   localparam logic [11:0] T_HIGH_DN  = T_HIGH - HYST;
   localparam logic [11:0] T_ALARM_DN = T_ALARM - HYST;

   localparam logic [PWM_BITS-1:0] DUTY_OFF  = '0;
   localparam logic [PWM_BITS-1:0] DUTY_LOW  = PWM_BITS'(1) << (PWM_BITS - 1);
   localparam logic [PWM_BITS-1:0] DUTY_HIGH = PWM_BITS'(3) << (PWM_BITS - 2);
   localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

   logic [11:0]         temp_q;
   state_t              state_q, state_d;
   logic [DW-1:0]       dwell_q, dwell_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic                fan_pwm_q, fan_pwm_d;
   logic                alarm_q, alarm_d;

   logic                dwell_met;
   logic                tick;
   logic                wrap;
   logic [PWM_BITS-1:0] target;

`ifdef TEMP_FAN_SOFTSTART_EN
   localparam logic [PWM_BITS-1:0] RAMP_STEP = PWM_BITS'(16);
   logic [PWM_BITS-1:0] gap;
   assign gap = target - duty_q;
`endif

   assign dwell_met = (dwell_q == DWELL_MAX);
   assign tick      = (presc_q == PRESC_MAX);
   // Period boundary: the tick on which the counter rolls over to 0.
   assign wrap      = tick && (pwm_cnt_q == '1);

   always_comb begin
      state_d   = state_q;
      dwell_d   = dwell_q;
      presc_d   = presc_q;
      pwm_cnt_d = pwm_cnt_q;
      duty_d    = duty_q;
      target    = DUTY_OFF;

      // Alarm entry bypasses the dwell timer; every other step waits for it.
      if ((state_q != ST_ALARM) && (temp_q >= T_ALARM)) begin
         state_d = ST_ALARM;
      end else if (dwell_met) begin
         case (state_q)
            ST_ALARM: if (temp_q < T_ALARM_DN) state_d = ST_HIGH;
            ST_OFF:   if (temp_q >= T_LOW)     state_d = ST_LOW;
            ST_LOW: begin
               if (temp_q >= T_HIGH)           state_d = ST_HIGH;
               else if (temp_q < T_LOW_DN)     state_d = ST_OFF;
            end
            ST_HIGH:  if (temp_q < T_HIGH_DN)  state_d = ST_LOW;
            default:  state_d = state_q;
         endcase
      end

      if (state_d != state_q) begin
         dwell_d = '0;
      end else if (!dwell_met) begin
         dwell_d = dwell_q + 1'b1;
      end

      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
         pwm_cnt_d = pwm_cnt_q + 1'b1;
      end

      case (state_q)
         ST_LOW:   target = DUTY_LOW;
         ST_HIGH:  target = DUTY_HIGH;
         ST_ALARM: target = DUTY_FULL;
         default:  target = DUTY_OFF;
      endcase

      // Duty only changes at the period boundary so no runt pulse is emitted.
      if (wrap) begin
`ifdef TEMP_FAN_SOFTSTART_EN
         if (target > duty_q) begin
            duty_d = duty_q + ((gap > RAMP_STEP) ? RAMP_STEP : gap);
         end else begin
            duty_d = target;
         end
`else
         duty_d = target;
`endif
      end

      // Uses the next state so the drive goes high on the same edge that
      // enters ALARM rather than waiting for the period boundary.
      fan_pwm_d = (state_d == ST_ALARM) ? 1'b1 : (pwm_cnt_q < duty_q);
      alarm_d   = (state_d == ST_ALARM);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         temp_q    <= '0;
         state_q   <= ST_OFF;
         dwell_q   <= '0;
         presc_q   <= '0;
         pwm_cnt_q <= '0;
         duty_q    <= '0;
         fan_pwm_q <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         temp_q    <= temp_in;
         state_q   <= state_d;
         dwell_q   <= dwell_d;
         presc_q   <= presc_d;
         pwm_cnt_q <= pwm_cnt_d;
         duty_q    <= duty_d;
         fan_pwm_q <= fan_pwm_d;
         alarm_q   <= alarm_d;
      end
   end

   assign fan_state = state_q;
   assign duty      = duty_q;
   assign fan_pwm   = fan_pwm_q;
   assign alarm     = alarm_q;

endmodule

// File: tb/tb_temp_fan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_temp_fan_ctrl
//
// Directed bench for temp_fan_ctrl (HOLD_CYCLES=16, PRESCALE=1). Stimulus
// pushes the expected fan_state changes (with the cycle they must occur on)
// and the expected sequence of duty values into queues; a monitor pops and
// compares whenever the DUT's fan_state or duty changes.
// Cycle numbering: cyc = number of rising edges since reset release.
// -----------------------------------------------------------------------------
module tb_temp_fan_ctrl;

   localparam int P = 256;   // PWM period in clk at PRESCALE=1

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [11:0] temp_in = 12'd0;
   logic [1:0]  fan_state;
   logic [7:0]  duty;
   logic        fan_pwm;
   logic        alarm;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      int st;
      int al;
      int at;
   } sexp_t;

   sexp_t sq[$];
   int    dq[$];
   int    dcur = 0;
   int    prev_st = 0;
   int    prev_duty = 0;
   sexp_t e_s;
   int    e_d;

   temp_fan_ctrl #(
      .PWM_BITS   (8),
      .PRESCALE   (1),
      .T_LOW      (12'd400),
      .T_HIGH     (12'd600),
      .T_ALARM    (12'd800),
      .HYST       (12'd20),
      .HOLD_CYCLES(16)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .temp_in  (temp_in),
      .fan_state(fan_state),
      .duty     (duty),
      .fan_pwm  (fan_pwm),
      .alarm    (alarm)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push_state(input int st, input int al, input int at);
      sexp_t e;
      e.st = st;
      e.al = al;
      e.at = at;
      sq.push_back(e);
   endfunction

   function automatic void push_duty(input int target);
`ifdef TEMP_FAN_SOFTSTART_EN
      while (dcur < target) begin
         dcur = dcur + (((target - dcur) > 16) ? 16 : (target - dcur));
         dq.push_back(dcur);
      end
      if (dcur > target) begin
         dcur = target;
         dq.push_back(dcur);
      end
`else
      if (dcur != target) begin
         dcur = target;
         dq.push_back(dcur);
      end
`endif
   endfunction

   // Monitor: every change of fan_state or duty is one transaction.
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_st   = 0;
         prev_duty = 0;
      end else begin
         if (int'(fan_state) != prev_st) begin
            if (sq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL state_unexpected: got %0d expected %0d (cycle %0d)",
                        fan_state, prev_st, cyc);
            end else begin
               e_s = sq.pop_front();
               $display("state %0d -> %0d alarm=%0d at cycle %0d",
                        prev_st, fan_state, alarm, cyc);
               chk("state_value", int'(fan_state), e_s.st);
               chk("state_alarm", int'(alarm), e_s.al);
               chk("state_cycle", cyc, e_s.at);
            end
            prev_st = int'(fan_state);
         end
         if (int'(duty) != prev_duty) begin
            if (dq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL duty_unexpected: got %0d expected %0d (cycle %0d)",
                        duty, prev_duty, cyc);
            end else begin
               e_d = dq.pop_front();
               $display("duty %0d -> %0d at cycle %0d", prev_duty, duty, cyc);
               chk("duty_value", int'(duty), e_d);
               chk("duty_boundary", cyc % P, 0);
            end
            prev_duty = int'(duty);
         end
      end
   end

   task automatic wait_until(input int c);
      int guard;
      guard = 0;
      while (cyc < c && guard < 50000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != c) begin
         checks++;
         errors++;
         $display("FAIL wait_until: got cycle %0d expected %0d", cyc, c);
      end
   endtask

   task automatic to_boundary(input int off);
      wait_until(((cyc / P) + 1) * P + off);
   endtask

   task automatic settle();
      int g;
      g = 0;
      while ((sq.size() != 0 || dq.size() != 0) && g < 16 * P) begin
         @(negedge clk);
         g++;
      end
      chk("pending_events", sq.size() + dq.size(), 0);
      to_boundary(10);
   endtask

   task automatic measure(output int hi);
      hi = 0;
      repeat (P) begin
         @(negedge clk);
         hi = hi + int'(fan_pwm);
      end
   endtask

   initial begin
      int t;
      int b;
      int hi;

      // Reset values, temp_in=450 held from release.
      temp_in = 12'd450;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_state", int'(fan_state), 0);
      chk("rst_duty",  int'(duty), 0);
      chk("rst_pwm",   int'(fan_pwm), 0);
      chk("rst_alarm", int'(alarm), 0);
      reset_n = 1'b1;

      // Step up: OFF->LOW on edge 16, duty 128 at the first boundary.
      push_state(1, 0, 16);
      push_duty(128);
      settle();
      measure(hi);
      chk("pwm_hi_low", hi, 128);

      // Hysteresis: 380 sits exactly at T_LOW-HYST and holds LOW.
      t = cyc;
      temp_in = 12'd380;
      wait_until(t + 40);
      chk("hyst_hold", int'(fan_state), 1);
      temp_in = 12'd379;
      push_state(0, 0, t + 42);
      push_duty(0);
      settle();

      // Alarm entry from LOW with dwell counter at 3.
      t = cyc;
      temp_in = 12'd450;
      push_state(1, 0, t + 2);
      wait_until(t + 5);
      temp_in = 12'd850;
      push_state(3, 1, t + 7);
      wait_until(t + 6);
      chk("pwm_pre_alarm", int'(fan_pwm), 0);
      wait_until(t + 7);
      chk("pwm_alarm", int'(fan_pwm), 1);
      chk("alarm_out", int'(alarm), 1);
      wait_until(t + 30);
      temp_in = 12'd785;
      wait_until(t + 40);
      chk("alarm_hold_785", int'(fan_state), 3);
      temp_in = 12'd780;
      wait_until(t + 50);
      chk("alarm_hold_780", int'(fan_state), 3);
      temp_in = 12'd779;
      push_state(2, 0, t + 52);
      wait_until(t + 52);
      chk("pwm_after_alarm", int'(fan_pwm), 0);
      push_duty(192);
      settle();
      measure(hi);
      chk("pwm_hi_high", hi, 192);

      // HIGH->LOW, then re-enter HIGH with pwm_cnt=50.
      t = cyc;
      temp_in = 12'd500;
      push_state(1, 0, t + 2);
      push_duty(128);
      settle();
      b = cyc - 10;
      wait_until(b + 48);
      temp_in = 12'd650;
      push_state(2, 0, b + 50);
      push_duty(192);
      wait_until(b + 255);
      chk("duty_hold_mid", int'(duty), 128);
      settle();

      // Asynchronous reset mid-period while in HIGH.
      wait_until(cyc + 80);
      chk("pre_rst_state", int'(fan_state), 2);
      temp_in = 12'd0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_state", int'(fan_state), 0);
      chk("arst_duty",  int'(duty), 0);
      chk("arst_pwm",   int'(fan_pwm), 0);
      chk("arst_alarm", int'(alarm), 0);
      dcur = 0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      measure(hi);
      chk("pwm_hi_off", hi, 0);
      chk("post_rst_state", int'(fan_state), 0);
      chk("post_rst_duty", int'(duty), 0);

      // Multi-band jumps advance one state per dwell period.
      to_boundary(10);
      t = cyc;
      temp_in = 12'd650;
      push_state(1, 0, t + 2);
      push_state(2, 0, t + 18);
      wait_until(t + 40);
      temp_in = 12'd0;
      push_state(1, 0, t + 42);
      push_state(0, 0, t + 58);
      wait_until(t + 60);
      settle();
      chk("final_duty", int'(duty), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
